// File: rtl/pool_window_buffer.sv
// rtl/pool_window_buffer.sv - assembles POOL x POOL raster windows for the min-pooling stage
module pool_window_buffer #(
    parameter int IL    = 8,
    parameter int FL    = 12,
    parameter int POOL  = 2,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic [IL+FL-1:0]   i_pix_in,
    input  logic               i_pix_valid,
    output logic               o_pix_ready,
    output logic [IL+FL-1:0]   o_win_out [POOL*POOL],
    output logic               o_pool_en,
    output logic               o_pool_start,
    input  logic               i_pool_done,
    output logic               o_res_valid,
    output logic               o_frame_done
);

    localparam int W    = IL + FL;
    localparam int SIZE = POOL * POOL;
    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW   = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int WCW  = $clog2(SIZE + 1);

    typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [PW-1:0]    r_cph;
    logic [PW-1:0]    r_rph;
    logic [WCW-1:0]   r_wait_cnt;
    logic [W-1:0]     r_win [SIZE];
    logic [W-1:0]     r_linebuf [POOL-1][IMG_W];
    logic             r_fill;
    logic             r_res_valid;
    logic             r_frame_done;

    logic             w_accept;
    logic             w_last_cph;
    logic             w_last_rph;
    logic             w_col_wrap;
    logic             w_row_wrap;
    logic             w_done_ok;

    assign w_accept   = i_en && i_pix_valid && o_pix_ready;
    assign w_last_cph = (r_cph == PW'(POOL - 1));
    assign w_last_rph = (r_rph == PW'(POOL - 1));
    assign w_col_wrap = (r_col == CW'(IMG_W - 1));
    assign w_row_wrap = (r_row == RW'(IMG_H - 1));
    // A done seen before the pooling stage could have walked the whole window is stale.
    assign w_done_ok  = i_en && (r_state == S_WAIT) && i_pool_done
                        && (r_wait_cnt >= WCW'(SIZE - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FILL;
        end else if (i_en) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FILL:  if (w_accept && w_last_rph && w_last_cph) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_done_ok) w_next = S_FILL;
            default: w_next = S_FILL;
        endcase
    end

    always_comb begin
        o_pix_ready  = i_en && r_fill;
        o_pool_start = i_en && (r_state == S_ISSUE);
        o_pool_en    = i_en;
    end

    // Registered decode of FILL so ready is low while reset is held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fill <= 1'b0;
        end else if (i_en) begin
            r_fill <= (w_next == S_FILL);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_cph        <= '0;
            r_rph        <= '0;
            r_wait_cnt   <= '0;
            r_res_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (i_en) begin
            if (w_accept) begin
                r_col <= w_col_wrap ? '0 : r_col + 1'b1;
                r_cph <= w_last_cph ? '0 : r_cph + 1'b1;
                if (w_col_wrap) begin
                    r_row <= w_row_wrap ? '0 : r_row + 1'b1;
                    r_rph <= w_last_rph ? '0 : r_rph + 1'b1;
                end
            end
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= '0;
            end else if ((r_state == S_WAIT) && (r_wait_cnt != WCW'(SIZE - 1))) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            r_res_valid  <= w_done_ok;
            r_frame_done <= w_done_ok && (r_row == '0) && (r_col == '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_accept && w_last_rph) begin
            for (int r = 0; r < POOL - 1; r++) begin
                for (int c = 0; c < POOL; c++) begin
                    if (PW'(c) == r_cph) begin
                        r_win[r*POOL + c] <= r_linebuf[r][r_col];
                    end
                end
            end
            for (int c = 0; c < POOL; c++) begin
                if (PW'(c) == r_cph) begin
                    r_win[(POOL-1)*POOL + c] <= i_pix_in;
                end
            end
        end
    end

    // Every line buffer slot is rewritten before it is read, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (w_accept && !w_last_rph) begin
            for (int r = 0; r < POOL - 1; r++) begin
                if (PW'(r) == r_rph) begin
                    r_linebuf[r][r_col] <= i_pix_in;
                end
            end
        end
    end

    assign o_win_out    = r_win;
    assign o_res_valid  = r_res_valid && i_en;
    assign o_frame_done = r_frame_done && i_en;

endmodule

// File: tb/tb_pool_window_buffer.sv
// tb/tb_pool_window_buffer.sv - scoreboard bench for pool_window_buffer
module tb_pool_window_buffer;

    localparam int IL    = 8;
    localparam int FL    = 12;
    localparam int POOL  = 2;
    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int SIZE  = POOL * POOL;
    localparam int W     = IL + FL;
    localparam int PW    = SIZE * W;

    typedef struct packed {
        logic [W-1:0] mn;
        logic         fd;
    } res_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [W-1:0]   pix_in = '0;
    logic           pix_valid = 1'b0;
    logic           pix_ready;
    logic [W-1:0]   win_out [SIZE];
    logic           pool_en;
    logic           pool_start;
    logic           pool_done;
    logic           res_valid;
    logic           frame_done;

    int checks = 0;
    int errors = 0;

    pool_window_buffer #(
        .IL(IL), .FL(FL), .POOL(POOL), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_pix_in     (pix_in),
        .i_pix_valid  (pix_valid),
        .o_pix_ready  (pix_ready),
        .o_win_out    (win_out),
        .o_pool_en    (pool_en),
        .o_pool_start (pool_start),
        .i_pool_done  (pool_done),
        .o_res_valid  (res_valid),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [PW-1:0] act_w;
    assign act_w = {win_out[3], win_out[2], win_out[1], win_out[0]};

    logic [PW-1:0] q_win [$];
    res_t          q_res [$];

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] pk(input int a, input int b, input int c, input int d);
        return {W'(d << FL), W'(c << FL), W'(b << FL), W'(a << FL)};
    endfunction

    function automatic logic [W-1:0] wmin(input logic [PW-1:0] w);
        logic [W-1:0] m;
        m = w[W-1:0];
        for (int i = 1; i < SIZE; i++) begin
            if (w[i*W +: W] < m) m = w[i*W +: W];
        end
        return m;
    endfunction

    // Reference min-pooling stage: done in its SIZE-th cycle after the load strobe.
    bit           done_const = 1'b0;
    logic         m_busy = 1'b0;
    int           m_cnt = 0;
    logic [W-1:0] m_res = '0;
    assign pool_done = done_const ? 1'b1 : (m_busy && (m_cnt == 0));

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
        end else if (pool_en) begin
            if (pool_start) begin
                m_busy <= 1'b1;
                m_cnt  <= SIZE - 1;
                m_res  <= wmin(act_w);
            end else if (m_busy) begin
                if (m_cnt == 0) m_busy <= 1'b0;
                else            m_cnt  <= m_cnt - 1;
            end
        end
    end

    int en_cyc = 0;
    int last_acc = 0;
    int start_cyc = 0;

    always @(posedge clk) begin
        if (en) begin
            if (pix_valid && pix_ready) last_acc <= en_cyc;
            en_cyc <= en_cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (pool_start) begin
            chk("window_expected", PW'(q_win.size() != 0), PW'(1));
            if (q_win.size() != 0) chk("window", act_w, q_win.pop_front());
            chk("start_latency", PW'(en_cyc), PW'(last_acc + 1));
            start_cyc = en_cyc;
        end
        if (res_valid) begin
            res_t e;
            chk("result_expected", PW'(q_res.size() != 0), PW'(1));
            if (q_res.size() != 0) begin
                e = q_res.pop_front();
                chk("frame_done", PW'(frame_done), PW'(e.fd));
                chk("pooled_min", PW'(m_res), PW'(e.mn));
            end
            chk("res_latency", PW'(en_cyc - start_cyc), PW'(SIZE + 1));
        end
        if (frame_done) chk("frame_done_with_res", PW'(res_valid), PW'(1));
    end

    task automatic push_frame();
        q_win.push_back(pk(1, 2, 5, 6));
        q_res.push_back('{mn: W'(1 << FL), fd: 1'b0});
        q_win.push_back(pk(3, 4, 7, 8));
        q_res.push_back('{mn: W'(3 << FL), fd: 1'b1});
    endtask

    task automatic send(input logic [W-1:0] v, input bit gapped);
        int g = 0;
        @(negedge clk);
        while (gapped && ($urandom_range(1, 0) == 1)) begin
            pix_valid = 1'b0;
            @(negedge clk);
        end
        pix_in    = v;
        pix_valid = 1'b1;
        while (!(pix_ready && en) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("send_timeout", PW'(0), PW'(1));
    endtask

    task automatic run_frame(input bit gapped);
        for (int k = 1; k <= IMG_W * IMG_H; k++) send(W'(k << FL), gapped);
    endtask

    task automatic end_stream();
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((q_win.size() != 0 || q_res.size() != 0) && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("drain", PW'(q_win.size() + q_res.size()), PW'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        chk("rst_win", act_w, PW'(0));
        chk("rst_pix_ready", PW'(pix_ready), PW'(0));
        chk("rst_pool_start", PW'(pool_start), PW'(0));
        chk("rst_res_valid", PW'(res_valid), PW'(0));
        chk("rst_frame_done", PW'(frame_done), PW'(0));
    endtask

    task automatic en_freeze();
        int g = 0;
        logic [PW-1:0] snap;
        @(negedge clk);
        while (!pool_start && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("freeze_wait_start", PW'(0), PW'(1));
        @(posedge clk);
        @(posedge clk);
        #1 en = 1'b0;
        snap = act_w;
        repeat (5) begin
            @(negedge clk);
            chk("freeze_pix_ready", PW'(pix_ready), PW'(0));
            chk("freeze_pool_en", PW'(pool_en), PW'(0));
            chk("freeze_res_valid", PW'(res_valid), PW'(0));
            chk("freeze_win", act_w, snap);
        end
        @(posedge clk);
        #1 en = 1'b1;
    endtask

    initial begin
        en = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        chk("rst_pool_en", PW'(pool_en), PW'(1));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_reset", PW'(pix_ready), PW'(1));

        push_frame();
        run_frame(1'b0);
        end_stream();
        drain();

        done_const = 1'b1;
        push_frame();
        run_frame(1'b0);
        end_stream();
        drain();
        done_const = 1'b0;

        push_frame();
        fork
            begin
                run_frame(1'b0);
                end_stream();
            end
            en_freeze();
        join
        drain();

        for (int k = 1; k <= 3; k++) send(W'(k << FL), 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        pix_valid = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_frame();
        run_frame(1'b0);
        end_stream();
        drain();

        push_frame();
        push_frame();
        run_frame(1'b1);
        run_frame(1'b1);
        end_stream();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/pool_window_buffer.md
Name: pool_window_buffer

Overview:
- Upstream feeder for the min-pooling stage of the CNN datapath.
- Accepts a raster-order fixed-point feature-map stream (one pixel per handshake) and assembles non-overlapping POOL x POOL windows (stride = POOL).
- Presents each window as a stable array to the pooling stage, pulses its start, holds the window until the pooling stage reports done, then signals that the pooled result is valid.

Parameters:
- IL, 8, integer bits of fixed-point sample
- FL, 12, fractional bits of fixed-point sample
- POOL, 2, window edge length (window holds POOL*POOL elements)
- IMG_W, 8, feature-map width in pixels; multiple of POOL
- IMG_H, 8, feature-map height in pixels; multiple of POOL
- size, POOL*POOL, window element count (derived)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  block enable; low freezes all state
- pix_in  input  IL+FL  incoming pixel
- pix_valid  input  1  pix_in valid
- pix_ready  output  1  block accepts pixel this cycle
- win_out  output  [IL+FL-1:0] x size (unpacked)  window to pooling stage
- pool_en  output  1  enable to pooling stage
- pool_start  output  1  one-cycle load strobe to pooling stage (its input_ready)
- pool_done  input  1  done from pooling stage
- res_valid  output  1  one-cycle pulse: pooling stage result register now holds the final window minimum
- frame_done  output  1  pulses together with res_valid for the last window of a frame

Behaviour:
- Reset (async, rst_n=0): state=FILL; col, row, wait_cnt=0; win_out elements=0; line buffer contents undefined; pix_ready, pool_start, res_valid, frame_done=0. pool_en = en (combinational), so it is 0 while en=0.
- Element order: win_out[r*POOL+c] holds the pixel at window row r, column c. win_out[0] is top-left.
- Line buffer: (POOL-1) x IMG_W entries.
- Pixel accept: pix_valid && pix_ready && en.
- State FILL (pix_ready=1). On accept:
  - If row%POOL < POOL-1: write linebuf[row%POOL][col].
  - Otherwise: write win_out[(POOL-1)*POOL + col%POOL] = pix_in, and for each r < POOL-1 write win_out[r*POOL + col%POOL] = linebuf[r][col].
  - col increments and wraps at IMG_W-1 to 0; row then increments and wraps at IMG_H-1 to 0.
  - If row%POOL==POOL-1 and col%POOL==POOL-1, next state is ISSUE.
- State ISSUE (pix_ready=0): pool_start=1 for exactly one cycle; wait_cnt cleared; next state is WAIT.
- State WAIT (pix_ready=0):
  - win_out is held stable.
  - wait_cnt increments and saturates at size-1.
  - pool_done is honoured only when wait_cnt >= size-1. This rejects stale done from the pooling pointer free-running in earlier states.
  - On an honoured done: res_valid=1 next cycle, and frame_done=1 in that same cycle if the window was the last one of the frame (row and col had wrapped to 0). Next state is FILL.
- Latency:
  - Window-completing pixel accepted at edge T; pool_start high in cycle T+1.
  - With the standard pooling stage, pool_done is high in cycle T+1+size.
  - res_valid is high in cycle T+2+size.
- Throughput: pixels are stalled only during ISSUE and WAIT, i.e. size+1 cycles per window.
- en=0: all registers hold, pix_ready=0, pool_start=0, pool_en=0, res_valid and frame_done forced 0. Operation resumes in place when en returns to 1.
- pool_done while in FILL or ISSUE: ignored.
- Frame boundary: counters wrap to 0 and the next frame starts without a gap. The line buffer is not cleared because every location is rewritten before it is read.
- Reset mid-window: immediately returns to FILL with counters at 0; any partial frame is discarded.

Test Plan:
- IMG_W=4, IMG_H=2, POOL=2. Stream pixels 1..8 (value k encoded as k<<12), pix_valid held high:
  - win_out = {1,2,5,6}<<12 after the 6th accept, pool_start pulses once.
  - Then win_out = {3,4,7,8}<<12 after the 8th accept.
  - frame_done pulses only with the second res_valid.
- Same stream with a min_pooling model attached: res_valid in cycle T+6 after each window-completing accept; pooled outputs 1<<12 and 3<<12.
- Hold pool_done=1 constantly from the bench: pool_start to res_valid is still at least size+1 cycles; no window is skipped.
- Deassert en for 5 cycles in the middle of WAIT: win_out, wait_cnt and state are frozen, pix_ready=0, pool_en=0; resuming completes with correct values.
- Assert rst_n=0 asynchronously between two clock edges mid-stream: outputs reach reset values immediately; the following frame of 1..8 reproduces the first scenario's windows exactly.
- Gapped pix_valid (random 50% duty) over two back-to-back frames: window contents and frame_done placement are identical to the ungapped run.
